// File: rtl/prog_loader.sv
// Boot loader: streams bytes into program then data memory, holds the CPU in reset until done.
// Write pulses are registered one cycle after each handshake; in_ready follows the state.
module prog_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] pm_len,
  input  logic [7:0] dm_len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       pm_we,
  output logic [6:0] pm_addr,
  output logic [7:0] pm_wdata,
  output logic       dm_we,
  output logic [6:0] dm_addr,
  output logic [7:0] dm_wdata,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, LOAD_PM, LOAD_DM, RELEASE, RUN} state_t;

  state_t     state, state_nxt;
  logic [7:0] pm_len_q, dm_len_q, pm_len_d, dm_len_d;
  logic [6:0] idx, idx_d;
  logic       err_d;
  logic       accept, pm_take, dm_take, len_ok, take_start;

  assign in_ready  = (state == LOAD_PM) || (state == LOAD_DM);
  assign busy      = in_ready || (state == RELEASE);
  assign cpu_reset = (state != RUN);
  assign done      = (state == RUN);

  // A byte handshaked together with abort is dropped.
  assign accept     = in_ready && in_valid && !abort;
  assign pm_take    = accept && (state == LOAD_PM);
  assign dm_take    = accept && (state == LOAD_DM);
  assign len_ok     = (pm_len <= 8'd128) && (dm_len <= 8'd128);
  assign take_start = start && !abort && ((state == IDLE) || (state == RUN));

  always_comb begin
    state_nxt = state;
    idx_d     = idx;
    pm_len_d  = pm_len_q;
    dm_len_d  = dm_len_q;
    err_d     = err;
    case (state)
      IDLE, RUN: begin
        if (take_start) begin
          if (len_ok) begin
            pm_len_d = pm_len;
            dm_len_d = dm_len;
            err_d    = 1'b0;
            idx_d    = 7'd0;
            if (pm_len != 8'd0)      state_nxt = LOAD_PM;
            else if (dm_len != 8'd0) state_nxt = LOAD_DM;
            else                     state_nxt = RELEASE;
          end else begin
            err_d     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      LOAD_PM: begin
        if (abort) begin
          err_d     = 1'b1;
          state_nxt = IDLE;
        end else if (accept) begin
          if ({1'b0, idx} == pm_len_q - 8'd1) begin
            idx_d     = 7'd0;
            state_nxt = (dm_len_q != 8'd0) ? LOAD_DM : RELEASE;
          end else begin
            idx_d = idx + 7'd1;
          end
        end
      end
      LOAD_DM: begin
        if (abort) begin
          err_d     = 1'b1;
          state_nxt = IDLE;
        end else if (accept) begin
          if ({1'b0, idx} == dm_len_q - 8'd1) begin
            idx_d     = 7'd0;
            state_nxt = RELEASE;
          end else begin
            idx_d = idx + 7'd1;
          end
        end
      end
      RELEASE: state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= 7'd0;
      pm_len_q <= 8'd0;
      dm_len_q <= 8'd0;
      err      <= 1'b0;
      pm_we    <= 1'b0;
      pm_addr  <= 7'd0;
      pm_wdata <= 8'd0;
      dm_we    <= 1'b0;
      dm_addr  <= 7'd0;
      dm_wdata <= 8'd0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_d;
      pm_len_q <= pm_len_d;
      dm_len_q <= dm_len_d;
      err      <= err_d;
      // Address/data are zeroed between pulses so idle buses stay quiet.
      pm_we    <= pm_take;
      pm_addr  <= pm_take ? idx : 7'd0;
      pm_wdata <= pm_take ? in_data : 8'd0;
      dm_we    <= dm_take;
      dm_addr  <= dm_take ? idx : 7'd0;
      dm_wdata <= dm_take ? in_data : 8'd0;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: acceptance table, directed load scenarios and randomized loads
// checked against a byte-list model of which writes each load must produce.
module tb_prog_loader;

  logic       clk, reset, start, abort, in_valid;
  logic [7:0] pm_len, dm_len, in_data;
  logic       in_ready, pm_we, dm_we, cpu_reset, busy, done, err;
  logic [6:0] pm_addr, dm_addr;
  logic [7:0] pm_wdata, dm_wdata;

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;
  logic [14:0] act_pm[$];
  logic [14:0] act_dm[$];

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pm_len(pm_len), .dm_len(dm_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write-port monitor: logs every pulse as {addr, data}.
  always @(negedge clk) begin
    if (pm_we) act_pm.push_back({pm_addr, pm_wdata});
    if (dm_we) act_dm.push_back({dm_addr, dm_wdata});
    if (pm_we && dm_we) excl_viol++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_we"}, {pm_we, dm_we}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One load: model says bytes[0..pl-1] go to PM addr 0.., the rest to DM addr 0..
  task automatic run_load(input int pl, input int dl, input int vprob,
                          input int abort_at, input int reset_at);
    logic [7:0] bytes[$];
    int total, sent, cyc, pb, db, npm, ndm;
    bit stop;
    total = pl + dl;
    sent = 0; cyc = 0; stop = 0;
    for (int i = 0; i < total; i++)
      bytes.push_back(i == 0 ? 8'h93 : 8'($urandom_range(0, 255)));
    pb = act_pm.size();
    db = act_dm.size();
    start = 1'b1; pm_len = 8'(pl); dm_len = 8'(dl); in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (sent < total && !stop) begin
      chk("load_in_ready", in_ready, 1);
      chk("load_busy", busy, 1);
      chk("load_cpu_reset", cpu_reset, 1);
      chk("load_done", done, 0);
      chk("load_err", err, 0);
      if (sent == reset_at) begin
        #2 reset = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        stop = 1;
      end else begin
        if (vprob < 0) in_valid = (cyc % 2 == 0);
        else           in_valid = (sent == abort_at) || ($urandom_range(1, 100) <= vprob);
        in_data = bytes[sent];
        abort   = (sent == abort_at);
        @(negedge clk);
        if (abort) begin
          abort = 1'b0;
          in_valid = 1'b0;
          stop = 1;
          chk("abort_in_ready", in_ready, 0);
          chk("abort_err", err, 1);
          chk("abort_busy", busy, 0);
          chk("abort_cpu_reset", cpu_reset, 1);
          chk("abort_done", done, 0);
        end else if (in_valid) begin
          sent++;
        end
        cyc++;
        if (cyc > 1000) begin
          chk("load_timeout", 1, 0);
          stop = 1;
        end
      end
    end
    in_valid = 1'b0;
    if (!stop) begin
      chk("release_in_ready", in_ready, 0);
      chk("release_busy", busy, 1);
      chk("release_cpu_reset", cpu_reset, 1);
      chk("release_done", done, 0);
      @(negedge clk);
      chk("run_in_ready", in_ready, 0);
      chk("run_busy", busy, 0);
      chk("run_cpu_reset", cpu_reset, 0);
      chk("run_done", done, 1);
      chk("run_err", err, 0);
    end
    repeat (2) @(negedge clk);
    npm = (sent < pl) ? sent : pl;
    ndm = (sent > pl) ? sent - pl : 0;
    chk("pm_count", act_pm.size() - pb, npm);
    chk("dm_count", act_dm.size() - db, ndm);
    for (int i = 0; i < npm && pb + i < act_pm.size(); i++) begin
      chk("pm_addr", int'(act_pm[pb + i][14:8]), i);
      chk("pm_wdata", int'(act_pm[pb + i][7:0]), int'(bytes[i]));
    end
    for (int i = 0; i < ndm && db + i < act_dm.size(); i++) begin
      chk("dm_addr", int'(act_dm[db + i][14:8]), i);
      chk("dm_wdata", int'(act_dm[db + i][7:0]), int'(bytes[pl + i]));
    end
    chk("we_exclusive", excl_viol, 0);
  endtask

  typedef struct {
    int pl;
    int dl;
    int e_err;
    int e_busy;
    int e_rdy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pb;
    vecs[0] = '{129, 0,   1, 0, 0};
    vecs[1] = '{0,   200, 1, 0, 0};
    vecs[2] = '{255, 255, 1, 0, 0};
    vecs[3] = '{128, 128, 0, 1, 1};
    vecs[4] = '{0,   5,   0, 1, 1};
    vecs[5] = '{0,   0,   0, 1, 0};
    vecs[6] = '{1,   0,   0, 1, 1};
    vecs[7] = '{128, 129, 1, 0, 0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    pm_len = 8'd0; dm_len = 8'd0; in_data = 8'd0;
    #3 chk_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_writes", act_pm.size() + act_dm.size(), 0);
    chk("idle_cpu_reset", cpu_reset, 1);

    // Start acceptance table: outputs one cycle after start from IDLE.
    foreach (vecs[k]) begin
      do_reset();
      start = 1'b1; pm_len = 8'(vecs[k].pl); dm_len = 8'(vecs[k].dl);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("tbl%0d_err", k), err, vecs[k].e_err);
      chk($sformatf("tbl%0d_busy", k), busy, vecs[k].e_busy);
      chk($sformatf("tbl%0d_in_ready", k), in_ready, vecs[k].e_rdy);
      chk($sformatf("tbl%0d_cpu_reset", k), cpu_reset, 1);
      chk($sformatf("tbl%0d_done", k), done, 0);
    end
    do_reset();

    run_load(44, 16, 100, -1, -1);
    run_load(10, 3, -1, -1, -1);
    run_load(20, 5, 100, 10, -1);

    // Rejected start, then a good one clears err.
    pb = act_pm.size() + act_dm.size();
    start = 1'b1; pm_len = 8'd129; dm_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("rej_err", err, 1);
    chk("rej_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("rej_busy_hold", busy, 0);
    chk("rej_no_writes", act_pm.size() + act_dm.size() - pb, 0);
    run_load(4, 0, 100, -1, -1);

    run_load(0, 0, 100, -1, -1);

    run_load(6, 10, 80, -1, 12);
    run_load(5, 5, 80, -1, -1);

    for (int r = 0; r < 8; r++)
      run_load($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(30, 100), -1, -1);
    run_load(128, 2, 90, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port start  input  1  load request, sampled each cycle.
REQ-004 SHALL have port abort  input  1  cancel an in-progress load.
REQ-005 SHALL have port pm_len  input  8  program-memory byte count, latched on accepted start.
REQ-006 SHALL have port dm_len  input  8  data-memory byte count, latched on accepted start.
REQ-007 SHALL have ports in_valid  input  1, in_data  input  8, in_ready  output  1  forming the byte-stream handshake.
REQ-008 SHALL have ports pm_we  output  1, pm_addr  output  7, pm_wdata  output  8  for the program-memory write port.
REQ-009 SHALL have ports dm_we  output  1, dm_addr  output  7, dm_wdata  output  8  for the data-memory write port.
REQ-010 SHALL have port cpu_reset  output  1  active-high hold-in-reset to the CPU.
REQ-011 SHALL have ports busy, done, err  output  1 each  status flags.

Function
REQ-012 SHALL implement states IDLE, LOAD_PM, LOAD_DM, RELEASE, RUN.
REQ-013 In IDLE, start=1 with pm_len<=128 and dm_len<=128 SHALL latch both lengths, clear err, and go to LOAD_PM, or to LOAD_DM if pm_len=0, or to RELEASE if both are 0.
REQ-014 In IDLE, start=1 with either length >128 SHALL set err=1 and remain in IDLE with no writes.
REQ-015 in_ready SHALL be 1 exactly when the state is LOAD_PM or LOAD_DM; a byte is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-016 Each accepted byte SHALL produce, on the next cycle only, a one-cycle write pulse on the port of the current state, with addr = byte index (0-based, per memory) and wdata = accepted in_data.
REQ-017 Acceptance of byte pm_len-1 in LOAD_PM SHALL transition to LOAD_DM, or to RELEASE if dm_len=0; acceptance of byte dm_len-1 in LOAD_DM SHALL transition to RELEASE.
REQ-018 The byte index counter SHALL reset to 0 on entry to each LOAD state; lengths <=128 guarantee that the 7-bit address never wraps.
REQ-019 RELEASE SHALL last exactly one cycle with cpu_reset=1, followed by RUN.
REQ-020 In RUN, outputs SHALL be cpu_reset=0 and done=1; other state outputs are at reset values.
REQ-021 start=1 in RUN SHALL behave as in REQ-013/014, with cpu_reset=1 and done=0 from the next cycle.
REQ-022 abort=1 in LOAD_PM/LOAD_DM SHALL go to IDLE, set err=1, and discard any byte handshaked in that cycle (no write pulse); abort SHALL be ignored in other states.
REQ-023 If start and abort are 1 in the same cycle, abort SHALL take priority.
REQ-024 busy SHALL be 1 in LOAD_PM, LOAD_DM, and RELEASE; otherwise 0.
REQ-025 cpu_reset SHALL be 1 in every state except RUN.
REQ-026 pm_we and dm_we SHALL never be 1 in the same cycle.

Reset
REQ-027 Asserting reset=0 SHALL immediately force IDLE, with cpu_reset=1, all other outputs=0, counters=0, and latched lengths=0, including mid-load.
REQ-028 After reset is released, the block SHALL wait in IDLE for start; no memory writes occur before then.

Verification
REQ-029 pm_len=44, dm_len=16, and 60 bytes streamed with in_valid held at 1 -> 44 pm_we pulses at addresses 0..43 (first wdata 0x93), then 16 dm_we pulses at addresses 0..15; cpu_reset falls and done rises 2 cycles after the last byte handshake.
REQ-030 Backpressure: in_valid toggles 1,0,1,0 during LOAD_PM -> writes occur only for handshaked bytes, addresses stay contiguous, and nothing is duplicated or skipped.
REQ-031 abort=1 on the cycle of byte 10 in LOAD_PM -> no write at address 10, state is IDLE, err=1, and cpu_reset stays 1.
REQ-032 pm_len=129 -> err=1, no writes, and busy stays 0; a following start with pm_len=4, dm_len=0 clears err and ends in RUN after 4 writes.
REQ-033 pm_len=0, dm_len=0 -> RELEASE next cycle and RUN the cycle after, with in_ready never 1.
REQ-034 reset=0 mid-LOAD_DM, then released -> IDLE, cpu_reset=1, done=0, and the next start reloads from address 0.
